// File: rtl/ua_buf_pkg.sv
// Shared types and constants for the analog unity-buffer scheduler.
// The state encoding, default sizing and a one-hot helper live here so that
// the arbiter, the top level and the interface all agree on them.
package ua_buf_pkg;

    localparam int MAX_REQ        = 8;
    localparam int N_REQ_DEF      = 4;
    localparam int DEAD_CYC_DEF   = 2;
    localparam int SETTLE_CYC_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BREAK = 2'd1,
        MAKE  = 2'd2,
        OWN   = 2'd3
    } state_t;

    // One-hot vector with bit idx set. Callers truncate it to their own width.
    function automatic logic [MAX_REQ-1:0] onehot(input int idx);
        return MAX_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/ua_buf_scheduler_if.sv
// Requester-side bundle of the unity-buffer scheduler.
// master: the requesting logic (drives req, sees switch/grant status).
// slave:  the scheduler (samples req, drives switch enables and status).
interface ua_buf_scheduler_if
    import ua_buf_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) ();

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] sw_en;
    logic [N_REQ-1:0] grant;
    logic             busy;
    logic             timeout;

    modport master (
        output req,
        input  sw_en,
        input  grant,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        output sw_en,
        output grant,
        output busy,
        output timeout
    );

endinterface

// File: rtl/rr_arbiter_comb.sv
// Combinational round-robin pick: the first set request strictly after the
// pointer, searching upward and wrapping. The pointer holds the last owner,
// so that owner ranks last on the next pick.
module rr_arbiter_comb
    import ua_buf_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic                     valid,
    output logic [N_REQ-1:0]         win_oh,
    output logic [$clog2(N_REQ)-1:0] win_idx
);

    localparam int IDX_W = $clog2(N_REQ);

    int cand;

    // Walk offsets 1..N_REQ from the pointer; the first hit wins.
    always_comb begin
        valid   = 1'b0;
        win_idx = '0;
        win_oh  = '0;
        cand    = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = (int'(ptr) + i) % N_REQ;
            if (!valid && (|(req & N_REQ'(onehot(cand))))) begin
                valid   = 1'b1;
                win_idx = IDX_W'(cand);
                win_oh  = N_REQ'(onehot(cand));
            end
        end
    end

endmodule

// File: rtl/ua_buf_scheduler.sv
// Time-shares the single analog unity buffer among N_REQ requesters.
// Round-robin pick, break-before-make dead time with all switches open,
// then a settle window with the winner's switch closed before grant.
// Optional build macro: AMUX_WATCHDOG_EN adds a hold watchdog that forces
// release after MAX_HOLD owned cycles while another requester is waiting.
//
// state | meaning
// IDLE  | all switches open, looking for a requester
// BREAK | winner latched, all switches open for DEAD_CYC cycles
// MAKE  | winner's switch closed, settling for SETTLE_CYC cycles
// OWN   | winner's switch closed and grant asserted until release
module ua_buf_scheduler
    import ua_buf_pkg::*;
#(
    parameter int N_REQ      = N_REQ_DEF,
    parameter int DEAD_CYC   = DEAD_CYC_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int MAX_HOLD   = 255,
    parameter int CNT_W      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    ua_buf_scheduler_if.slave   bus
);

    localparam int IDX_W = $clog2(N_REQ);

    // Down-counter load values; each phase ends when the counter reads 0.
    localparam logic [CNT_W-1:0] DEAD_LD   = CNT_W'(DEAD_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(MAX_HOLD - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [N_REQ-1:0]   sel_oh_q, sel_oh_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_REQ-1:0]   sw_en_q, sw_en_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic               busy_q, busy_d;

    logic               arb_valid;
    logic [N_REQ-1:0]   arb_oh;
    logic [IDX_W-1:0]   arb_idx;
    logic               sel_req;

    rr_arbiter_comb #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req     (bus.req),
        .ptr     (ptr_q),
        .valid   (arb_valid),
        .win_oh  (arb_oh),
        .win_idx (arb_idx)
    );

    assign sel_req = |(bus.req & sel_oh_q);

`ifdef AMUX_WATCHDOG_EN
    logic others_wait;
    logic timeout_q, timeout_d;

    assign others_wait = |(bus.req & ~sel_oh_q);
`endif

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        sel_d    = sel_q;
        sel_oh_d = sel_oh_q;
        cnt_d    = cnt_q;
`ifdef AMUX_WATCHDOG_EN
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (arb_valid) begin
                    sel_d    = arb_idx;
                    sel_oh_d = arb_oh;
                    cnt_d    = DEAD_LD;
                    state_d  = BREAK;
                end
            end
            BREAK: begin
                if (!sel_req) begin
                    ptr_d   = sel_q;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    cnt_d   = SETTLE_LD;
                    state_d = MAKE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            MAKE: begin
                if (!sel_req) begin
                    ptr_d   = sel_q;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    cnt_d   = HOLD_LD;
                    state_d = OWN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            OWN: begin
                if (!sel_req) begin
                    ptr_d   = sel_q;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
`ifdef AMUX_WATCHDOG_EN
                else if (!others_wait) begin
                    cnt_d = HOLD_LD;
                end else if (cnt_q == '0) begin
                    ptr_d     = sel_q;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
`endif
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        sw_en_d = '0;
        grant_d = '0;
        if (state_d == MAKE || state_d == OWN) sw_en_d = sel_oh_d;
        if (state_d == OWN)                    grant_d = sel_oh_d;
        busy_d = (state_d != IDLE);
    end

    // State, pointer, counter and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= IDX_W'(N_REQ - 1);
            sel_q    <= '0;
            sel_oh_q <= '0;
            cnt_q    <= '0;
            sw_en_q  <= '0;
            grant_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            sel_q    <= sel_d;
            sel_oh_q <= sel_oh_d;
            cnt_q    <= cnt_d;
            sw_en_q  <= sw_en_d;
            grant_q  <= grant_d;
            busy_q   <= busy_d;
        end
    end

`ifdef AMUX_WATCHDOG_EN
    // One-cycle pulse marking a watchdog forced release.
    always_ff @(posedge clk) begin
        if (!rst_n) timeout_q <= 1'b0;
        else        timeout_q <= timeout_d;
    end

    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.sw_en = sw_en_q;
    assign bus.grant = grant_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_ua_buf_scheduler.sv
// Bench for ua_buf_scheduler: directed scenarios then random requests, every
// cycle compared against a timeline model (owner, latch time, rotation pointer).
module tb_ua_buf_scheduler;

    localparam int N      = 4;
    localparam int DEAD   = 2;
    localparam int SETTLE = 4;
    localparam int MAXH   = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    ua_buf_scheduler_if #(.N_REQ(N)) bus ();

    ua_buf_scheduler #(
        .N_REQ      (N),
        .DEAD_CYC   (DEAD),
        .SETTLE_CYC (SETTLE),
        .MAX_HOLD   (MAXH),
        .CNT_W      (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model: who owns the buffer, at which edge it was latched,
    // and where the rotation stands. Outputs follow from elapsed edges.
    int         cyc     = 0;
    bit         m_busy  = 1'b0;
    int         m_sel   = 0;
    int         m_start = 0;
    int         m_ptr   = N - 1;
    int         m_hold  = 0;
    bit         m_tmo   = 1'b0;
    logic [N-1:0] exp_sw  = '0;
    logic [N-1:0] exp_gnt = '0;

    // Scenario scratch.
    logic [N-1:0] sw_h [0:8];
    logic [N-1:0] g_h  [0:8];
    int           order[$];
    int           exp_order[5];
    int           gap, held, tmo_at, g_at;
    bit           seen;
    logic [N-1:0] r, last_g;

    function automatic bit has(logic [N-1:0] v, int i);
        return |(v & (N'(1) << i));
    endfunction

    function automatic int idx_of(logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (has(v, i)) return i;
        return -1;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(logic [N-1:0] rq, logic rb);
        int e;
        int c;
        cyc++;
        m_tmo = 1'b0;
        if (!rb) begin
            m_busy = 1'b0;
            m_ptr  = N - 1;
            m_hold = 0;
        end else if (!m_busy) begin
            for (int k = 1; k <= N; k++) begin
                c = (m_ptr + k) % N;
                if (!m_busy && has(rq, c)) begin
                    m_busy  = 1'b1;
                    m_sel   = c;
                    m_start = cyc;
                    m_hold  = 0;
                end
            end
        end else begin
            e = cyc - m_start;
            if (!has(rq, m_sel)) begin
                m_busy = 1'b0;
                m_ptr  = m_sel;
            end
`ifdef AMUX_WATCHDOG_EN
            else if (e > DEAD + SETTLE) begin
                if ((rq & ~(N'(1) << m_sel)) != '0) begin
                    m_hold++;
                    if (m_hold == MAXH) begin
                        m_busy = 1'b0;
                        m_ptr  = m_sel;
                        m_tmo  = 1'b1;
                    end
                end else begin
                    m_hold = 0;
                end
            end
`endif
        end
        exp_sw  = '0;
        exp_gnt = '0;
        if (m_busy) begin
            e = cyc - m_start;
            if (e >= DEAD)          exp_sw  = N'(1) << m_sel;
            if (e >= DEAD + SETTLE) exp_gnt = N'(1) << m_sel;
        end
    endtask

    task automatic step(logic [N-1:0] rq, logic rb);
        @(negedge clk);
        bus.req = rq;
        rst_n   = rb;
        @(posedge clk);
        model_edge(rq, rb);
        #1;
        chk("sw_en",   32'(bus.sw_en),   32'(exp_sw));
        chk("grant",   32'(bus.grant),   32'(exp_gnt));
        chk("busy",    32'(bus.busy),    32'(m_busy));
        chk("timeout", 32'(bus.timeout), 32'(m_tmo));
        chk("sw_onehot0",  32'($onehot0(bus.sw_en)),      32'(1));
        chk("grant_no_sw", 32'(bus.grant & ~bus.sw_en),   32'(0));
    endtask

    initial begin
        bus.req = '0;

        // 1: reset, then single requester 0.
        step('0, 1'b0);
        step('0, 1'b0);
        step('0, 1'b1);
        step(4'b0001, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            step(4'b0001, 1'b1);
            sw_h[k] = bus.sw_en;
            g_h[k]  = bus.grant;
        end
        chk("t1_sw_dead",   32'(sw_h[1]), 32'(0));
        chk("t1_sw_on",     32'(sw_h[2]), 32'(1));
        chk("t1_gnt_settle",32'(g_h[5]),  32'(0));
        chk("t1_gnt_on",    32'(g_h[6]),  32'(1));
        step('0, 1'b1);
        chk("t1_release_busy", 32'(bus.busy), 32'(0));

        // 2: all requesting, each owner drops req 10 cycles after grant.
        step('0, 1'b0);
        exp_order = '{0, 1, 2, 3, 0};
        order.delete();
        gap = 0; held = 0; seen = 1'b0; last_g = '0;
        for (int k = 0; k < 300 && order.size() < 5; k++) begin
            r = 4'b1111;
            if (exp_gnt != '0 && held >= 10) r = ~exp_gnt;
            step(r, 1'b1);
            if (exp_gnt != '0) held++;
            else               held = 0;
            if (bus.grant != '0 && bus.grant != last_g) order.push_back(idx_of(bus.grant));
            last_g = bus.grant;
            if (bus.sw_en == '0) begin
                gap++;
            end else begin
                if (seen && gap > 0) chk("t2_gap_ge3", 32'(gap >= 3), 32'(1));
                gap  = 0;
                seen = 1'b1;
            end
        end
        chk("t2_owner_count", 32'(order.size()), 32'(5));
        for (int i = 0; i < 5; i++)
            chk("t2_order", (i < order.size()) ? 32'(order[i]) : 32'hffff_ffff, 32'(exp_order[i]));

        // 3: req[2] drops during MAKE; pending req[3] wins next.
        step('0, 1'b0);
        step(4'b1100, 1'b1);
        for (int k = 0; k < 3; k++) step(4'b1100, 1'b1);
        step(4'b1000, 1'b1);
        chk("t3_abort_busy",  32'(bus.busy),  32'(0));
        chk("t3_abort_sw",    32'(bus.sw_en), 32'(0));
        chk("t3_abort_grant", 32'(bus.grant), 32'(0));
        for (int k = 0; k < 7; k++) step(4'b1000, 1'b1);
        chk("t3_next_owner", 32'(bus.grant), 32'(4'b1000));

        // 4: reset while owned, then req 1001 -> requester 0 first.
        step('0, 1'b0);
        for (int k = 0; k < 9; k++) step(4'b0010, 1'b1);
        chk("t4_owned", 32'(bus.grant), 32'(4'b0010));
        step(4'b0010, 1'b0);
        chk("t4_rst_busy",  32'(bus.busy),  32'(0));
        chk("t4_rst_sw",    32'(bus.sw_en), 32'(0));
        chk("t4_rst_grant", 32'(bus.grant), 32'(0));
        for (int k = 0; k < 7; k++) step(4'b1001, 1'b1);
        chk("t4_winner", 32'(bus.grant), 32'(4'b0001));

`ifdef AMUX_WATCHDOG_EN
        // 5: watchdog forces requester 0 off once requester 1 waits MAXH cycles.
        step('0, 1'b0);
        for (int k = 0; k < 7; k++) step(4'b0001, 1'b1);
        tmo_at = -1; g_at = -1;
        for (int k = 1; k <= 40 && g_at < 0; k++) begin
            step(4'b0011, 1'b1);
            if (bus.timeout && tmo_at < 0) tmo_at = k;
            if (bus.grant == 4'b0010) g_at = k;
        end
        chk("t5_timeout_at", 32'(tmo_at), 32'(MAXH));
        chk("t5_grant_lag",  32'(g_at - tmo_at), 32'(DEAD + SETTLE + 1));
`endif

        // 6: random request traffic with occasional reset.
        step('0, 1'b0);
        r = '0;
        for (int k = 0; k < 4000; k++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(7) == 0) r = r ^ (N'(1) << b);
            step(r, ($urandom_range(499) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
